// File: rtl/fifo_rd_drain.sv
// Read-side drain for an async FIFO: credit-gated pops, read-latency tag pipe,
// skid buffer and a framed valid/ready output stream in the rclk domain.
module fifo_rd_drain #(
  parameter int WIDTH     = 32,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                             rclk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             fifo_rempty,
  input  logic [WIDTH-1:0]                 fifo_rdata,
  output logic                             fifo_rinc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic [$clog2(FRAME_LEN+1)-1:0]   beat_cnt
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BC_W  = $clog2(FRAME_LEN + 1);
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(FRAME_LEN - 1);

  logic                 r_run;
  logic [RD_LAT-1:0]    r_tag;
  logic [OCC_W-1:0]     r_occ;
  logic [OCC_W-1:0]     r_cnt;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [WIDTH-1:0]     r_mem [BUF_DEPTH];
  logic [BC_W-1:0]      r_beat;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;

  logic                 w_pop;
  logic                 w_wr;
  logic                 w_xfer;
  logic [RD_LAT-1:0]    w_tag_nxt;
  logic [OCC_W-1:0]     w_occ_nxt;
  logic [OCC_W-1:0]     w_cnt_nxt;
  logic [PTR_W-1:0]     w_wptr_nxt;
  logic [PTR_W-1:0]     w_rptr_nxt;
  logic [BC_W-1:0]      w_beat_nxt;
  logic                 w_valid_nxt;
  logic                 w_last_nxt;

  // Pop/credit decision, occupancy and pointer next-state.
  // Credit uses last cycle's occupancy, so a same-cycle transfer frees a slot
  // only from the following cycle on; r_run keeps pops off while in reset.
  always_comb begin
    w_pop        = r_run & en & ~fifo_rempty & (r_occ < OCC_MAX);
    w_wr         = r_tag[RD_LAT-1];
    w_xfer       = r_valid & out_ready;
    w_tag_nxt    = r_tag << 1;
    w_tag_nxt[0] = w_pop;

    case ({w_pop, w_xfer})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase

    case ({w_wr, w_xfer})
      2'b10:   w_cnt_nxt = r_cnt + OCC_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - OCC_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase

    if (w_wr) begin
      w_wptr_nxt = (r_wptr == PTR_LAST) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1);
    end else begin
      w_wptr_nxt = r_wptr;
    end

    if (w_xfer) begin
      w_rptr_nxt = (r_rptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
  end

  // Frame beat counter next-state and registered stream flags.
  always_comb begin
    if (w_xfer) begin
      w_beat_nxt = r_last ? {BC_W{1'b0}} : r_beat + BC_W'(1);
    end else begin
      w_beat_nxt = r_beat;
    end
    w_valid_nxt = (w_cnt_nxt != {OCC_W{1'b0}});
    w_last_nxt  = w_valid_nxt & (w_beat_nxt == BEAT_LAST);
  end

  // Control state: run flag, tag pipe, occupancy, pointers, frame counter.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_tag   <= {RD_LAT{1'b0}};
      r_occ   <= {OCC_W{1'b0}};
      r_cnt   <= {OCC_W{1'b0}};
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_beat  <= {BC_W{1'b0}};
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_tag   <= w_tag_nxt;
      r_occ   <= w_occ_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_beat  <= w_beat_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= (w_occ_nxt != {OCC_W{1'b0}});
    end
  end

  // Skid buffer storage; cleared so out_data reads zero out of reset.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wr) begin
      r_mem[r_wptr] <= fifo_rdata;
    end else begin
      r_mem[r_wptr] <= r_mem[r_wptr];
    end
  end

  assign fifo_rinc = w_pop;
  assign out_valid = r_valid;
  assign out_data  = r_mem[r_rptr];
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign beat_cnt  = r_beat;

  fifo_rd_drain_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .OCC_W     (OCC_W),
    .WIDTH     (WIDTH)
  ) u_chk (
    .i_rclk        (rclk),
    .i_rst_n       (rst_n),
    .i_fifo_rempty (fifo_rempty),
    .i_fifo_rinc   (w_pop),
    .i_wr          (w_wr),
    .i_out_valid   (r_valid),
    .i_out_ready   (out_ready),
    .i_occ         (r_occ),
    .i_cnt         (r_cnt),
    .i_out_data    (out_data)
  );

endmodule

// Invariants of the drain: no pop while empty, no write into a full buffer,
// occupancy bounds and output hold under back-pressure.
module fifo_rd_drain_chk #(
  parameter int BUF_DEPTH = 4,
  parameter int OCC_W     = 3,
  parameter int WIDTH     = 32
) (
  input logic             i_rclk,
  input logic             i_rst_n,
  input logic             i_fifo_rempty,
  input logic             i_fifo_rinc,
  input logic             i_wr,
  input logic             i_out_valid,
  input logic             i_out_ready,
  input logic [OCC_W-1:0] i_occ,
  input logic [OCC_W-1:0] i_cnt,
  input logic [WIDTH-1:0] i_out_data
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(BUF_DEPTH);

  a_no_pop_empty: assert property (@(posedge i_rclk) disable iff (!i_rst_n)
    !(i_fifo_rinc && i_fifo_rempty));

  a_no_overflow: assert property (@(posedge i_rclk) disable iff (!i_rst_n)
    !(i_wr && (i_cnt == OCC_MAX)));

  a_occ_bound: assert property (@(posedge i_rclk) disable iff (!i_rst_n)
    (i_occ <= OCC_MAX) && (i_cnt <= i_occ));

  a_hold: assert property (@(posedge i_rclk) disable iff (!i_rst_n)
    (i_out_valid && !i_out_ready) |=> (i_out_valid && $stable(i_out_data)));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: upstream FIFO model with 2-cycle read latency,
// scoreboard on the output stream, vector table plus corner-case sequences.
module tb_fifo_rd_drain;

  localparam int W         = 32;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;
  localparam int FRAME_LEN = 4;
  localparam int BC_W      = $clog2(FRAME_LEN + 1);

  logic            rclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            fifo_rempty;
  logic [W-1:0]    fifo_rdata;
  logic            fifo_rinc;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            busy;
  logic [BC_W-1:0] beat_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_drain #(
    .WIDTH (W), .RD_LAT (RD_LAT), .BUF_DEPTH (BUF_DEPTH), .FRAME_LEN (FRAME_LEN)
  ) dut (
    .rclk (rclk), .rst_n (rst_n), .en (en), .fifo_rempty (fifo_rempty),
    .fifo_rdata (fifo_rdata), .fifo_rinc (fifo_rinc), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .out_last (out_last),
    .busy (busy), .beat_cnt (beat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Upstream async FIFO read port: word popped at cycle t is on fifo_rdata at t+2.
  logic [W-1:0] up_mem [0:63];
  int           up_wr = 0;
  int           up_rd;
  logic [W-1:0] pipe0, pipe1;
  int           cyc = 0;

  assign fifo_rempty = (up_rd >= up_wr);
  assign fifo_rdata  = pipe1;

  always @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      up_rd <= 0;
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      if (fifo_rinc) begin
        up_rd <= up_rd + 1;
        pipe0 <= up_mem[up_rd];
      end else begin
        pipe0 <= {16'hDEAD, cyc[15:0]};
      end
      pipe1 <= pipe0;
    end
  end

  initial forever begin
    @(posedge rclk);
    cyc++;
  end

  // Scoreboard and stream monitor, sampled on the falling edge.
  logic [W-1:0] exp_q [$];
  int           pop_cnt, xfer_n, first_pop, last_pop, last_xfer, busy_fall, lasts, mdl_beat;
  int           xfer_cyc [0:63];
  logic         prev_stall, prev_busy;
  logic [W-1:0] prev_data;

  initial forever begin
    @(negedge rclk);
    if (!rst_n) begin
      pop_cnt = 0; xfer_n = 0; first_pop = -1; last_pop = -1; last_xfer = -1;
      busy_fall = -1; lasts = 0; mdl_beat = 0; prev_stall = 1'b0; prev_busy = 1'b0;
      exp_q.delete();
    end else begin
      if (fifo_rinc) begin
        check("rinc_while_empty", fifo_rempty, 0);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got 0x%0h, expected no beat", out_data);
        end else begin
          check("beat_data", out_data, exp_q.pop_front());
        end
        check("beat_last", out_last, (mdl_beat == FRAME_LEN - 1));
        if (out_last) lasts++;
        mdl_beat = (mdl_beat == FRAME_LEN - 1) ? 0 : mdl_beat + 1;
        if (xfer_n < 64) xfer_cyc[xfer_n] = cyc;
        xfer_n++;
        last_xfer = cyc;
      end else if (!out_valid) begin
        check("last_without_valid", out_last, 0);
      end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy  = busy;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; up_wr = 0;
    repeat (2) @(posedge rclk);
    #1 rst_n = 1'b1;
  endtask

  // Put n words into the upstream FIFO; only the first n_exp are expected out.
  task automatic load(input int n, input logic [W-1:0] base, input int n_exp);
    for (int i = 0; i < n; i++) begin
      up_mem[up_wr] = base + W'(i);
      up_wr++;
      if (i < n_exp) exp_q.push_back(base + W'(i));
    end
  endtask

  task automatic run_drain(input int mode, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k >= 12);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge rclk); #1;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left, expected 0", exp_q.size());
    end
    out_ready = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
  endtask

  typedef struct {
    int           n;
    logic [W-1:0] base;
    int           mode;
    int           exp_pops;
    int           exp_beat;
    int           exp_lasts;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{n: 10, base: 32'h0000_0100, mode: 0, exp_pops: 10, exp_beat: 2, exp_lasts: 2};
    vecs[1] = '{n: 8,  base: 32'h0000_0200, mode: 1, exp_pops: 8,  exp_beat: 0, exp_lasts: 2};
    vecs[2] = '{n: 13, base: 32'hA5A5_0000, mode: 2, exp_pops: 13, exp_beat: 1, exp_lasts: 3};
    vecs[3] = '{n: 1,  base: 32'hDEAD_BEEF, mode: 0, exp_pops: 1,  exp_beat: 1, exp_lasts: 0};
    vecs[4] = '{n: 5,  base: 32'h5555_AAAA, mode: 2, exp_pops: 5,  exp_beat: 1, exp_lasts: 1};

    // Values held in reset.
    #1;
    check("rst_rinc", fifo_rinc, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_beat", beat_cnt, 0);
    check("rst_data", out_data, 0);

    // Empty upstream: nothing moves for 20 cycles.
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge rclk); #1;
      check("idle_rinc", fifo_rinc, 0);
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
    end

    // 8-word burst at full rate: back-to-back pops, first beat 3 cycles after first pop.
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    load(8, 32'h0, 8);
    run_drain(0, 100);
    check("burst_pops", pop_cnt, 8);
    check("burst_pop_span", last_pop - first_pop, 7);
    check("burst_beats", xfer_n, 8);
    for (int i = 0; i < 8; i++) check("burst_beat_cycle", xfer_cyc[i] - first_pop, 3 + i);

    // Back-pressure: credit stops pops at BUF_DEPTH, head word held.
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    load(8, 32'h0, 8);
    repeat (15) @(posedge rclk);
    #1;
    check("stall_pops", pop_cnt, BUF_DEPTH);
    check("stall_rinc", fifo_rinc, 0);
    check("stall_head_valid", out_valid, 1);
    check("stall_head_data", out_data, 32'h0);
    check("stall_busy", busy, 1);
    run_drain(0, 100);
    check("stall_total_pops", pop_cnt, 8);
    check("stall_total_beats", xfer_n, 8);

    // en drop after 3 pops: the 3 words still drain, busy falls a cycle later.
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    load(8, 32'h30, 3);
    for (int i = 0; i < 50 && en; i++) begin
      @(posedge rclk); #1;
      if (pop_cnt >= 3) en = 1'b0;
    end
    run_drain(0, 100);
    check("endrop_pops", pop_cnt, 3);
    check("endrop_beats", xfer_n, 3);
    check("endrop_rinc", fifo_rinc, 0);
    check("endrop_busy_fall", busy_fall - last_xfer, 1);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      en = 1'b1;
      load(vecs[v].n, vecs[v].base, vecs[v].n);
      run_drain(vecs[v].mode, 400);
      check("vec_pops", pop_cnt, vecs[v].exp_pops);
      check("vec_beat_cnt", beat_cnt, vecs[v].exp_beat);
      check("vec_lasts", lasts, vecs[v].exp_lasts);
      check("vec_busy", busy, 0);
      check("vec_valid", out_valid, 0);
    end

    // Reset with 2 words buffered and 2 in flight; nothing stale afterwards.
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    load(8, 32'h60, 8);
    for (int i = 0; i < 50 && pop_cnt < 4; i++) begin
      @(posedge rclk); #1;
    end
    check("midrst_pre_valid", out_valid, 1);
    check("midrst_pre_busy", busy, 1);
    rst_n = 1'b0; up_wr = 0;
    #1;
    check("midrst_rinc", fifo_rinc, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_beat", beat_cnt, 0);
    check("midrst_data", out_data, 0);
    repeat (2) @(posedge rclk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge rclk); #1;
      check("postrst_valid", out_valid, 0);
      check("postrst_rinc", fifo_rinc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
